// File: rtl/wb_master_engine.sv
// wb_master_engine: command FIFO feeding a Wishbone classic master, one response per bus cycle.
// Defining WB_MASTER_TIMEOUT_EN adds a BUS-state cycle limit (TIMEOUT_CYCLES) that forces an error response.
module wb_master_engine #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic                    rsp_err_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    busy_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH + SEL_W;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(CMD_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0] mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, empty, push, pop;

  logic                  hd_we;
  logic [ADDR_WIDTH-1:0] hd_adr;
  logic [DATA_WIDTH-1:0] hd_dat;
  logic [SEL_W-1:0]      hd_sel;

  logic                  cyc_q, cyc_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  tmo_hit, term;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == ST_IDLE) && !empty;
  // A pop in this cycle frees a slot, so a full FIFO can still accept.
  assign cmd_ready_o = !full || pop;
  assign push  = cmd_valid_i && cmd_ready_o;
  assign {hd_we, hd_adr, hd_dat, hd_sel} = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == ST_BUS) && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = '0;
    if (state_q == ST_BUS && !term) tmo_d = tmo_q + TMO_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign term = ack_i || err_i || tmo_hit;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = hd_we;
          adr_d   = hd_adr;
          dat_d   = hd_dat;
          sel_d   = hd_sel;
        end
      end
      ST_BUS: begin
        if (term) begin
          state_d   = ST_RESP;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          adr_d     = '0;
          dat_d     = '0;
          sel_d     = '0;
          // Timeout is the only way to terminate with neither ack_i nor err_i.
          rsp_err_d = err_i || !ack_i;
          rsp_dat_d = (ack_i && !err_i && !we_q) ? dat_i : '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d   = ST_IDLE;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = sel_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_master_engine.sv
// Self-checking bench for wb_master_engine: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_wb_master_engine;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [15:0] cmd_dat_i = '0;
  logic [1:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o;
  logic [15:0] dat_o;
  logic [1:0]  sel_o;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic [15:0] dat_i = '0;
  logic        busy_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int unsigned waits;
    logic        ack;
    logic        err;
    logic [15:0] sdat;
    int unsigned exp_cyc;
    logic        exp_err;
    logic [15:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } cmd_t;

  wb_master_engine #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (16),
    .CMD_DEPTH     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_sel_i  (cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .sel_o      (sel_o),
    .ack_i      (ack_i),
    .err_i      (err_i),
    .dat_i      (dat_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int unsigned n;
    cmd_valid_i = 1'b1;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    chk({tag, ".ready"}, cmd_ready_o, 1);
    step;
    cmd_valid_i = 1'b0;
    cmd_adr_i   = '0;
    chk({tag, ".busy_after_push"}, busy_o, 1);
    chk({tag, ".cyc_not_early"}, cyc_o, 0);
    step;
    n = 0;
    while (cyc_o === 1'b1 && n < 60) begin
      if (n == 0) begin
        chk({tag, ".stb"}, stb_o, 1);
        chk({tag, ".we"},  we_o,  v.we);
        chk({tag, ".adr"}, adr_o, v.adr);
        chk({tag, ".dat"}, dat_o, v.dat);
        chk({tag, ".sel"}, sel_o, v.sel);
      end
      if (n == v.waits) begin
        ack_i = v.ack;
        err_i = v.err;
        dat_i = v.sdat;
      end else begin
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = 16'($urandom);
      end
      step;
      n++;
    end
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    chk({tag, ".cyc_cycles"}, n, v.exp_cyc);
    chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_err"}, rsp_err_o, v.exp_err);
    chk({tag, ".rsp_dat"}, rsp_dat_o, v.exp_dat);
    chk({tag, ".adr_idle"}, adr_o, 0);
    step;
    chk({tag, ".rsp_hold_valid"}, rsp_valid_o, 1);
    chk({tag, ".rsp_hold_dat"}, rsp_dat_o, v.exp_dat);
    rsp_ready_i = 1'b1;
    step;
    rsp_ready_i = 1'b0;
    chk({tag, ".rsp_done"}, rsp_valid_o, 0);
    chk({tag, ".idle_busy"}, busy_o, 0);
  endtask

  // Five pushes into a stalled slave, a sixth waiting at full, then drain in order.
  task automatic seq_full;
    int unsigned g;
    cmd_we_i  = 1'b0;
    cmd_dat_i = '0;
    cmd_sel_i = 2'b11;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_adr_i = 32'h100 + 32'(i);
      chk($sformatf("full.ready_push%0d", i), cmd_ready_o, 1);
      step;
    end
    cmd_adr_i = 32'h105;
    chk("full.ready_low", cmd_ready_o, 0);
    for (int i = 0; i < 2; i++) begin
      step;
      chk("full.stall_ready", cmd_ready_o, 0);
      chk("full.stall_adr", adr_o, 32'h100);
    end
    for (int k = 0; k < 6; k++) begin
      g = 0;
      while (cyc_o !== 1'b1 && g < 8) begin
        step;
        cmd_valid_i = 1'b0;
        g++;
      end
      chk($sformatf("full.order%0d", k), adr_o, 32'h100 + 32'(k));
      ack_i = 1'b1;
      dat_i = 16'hA000 + 16'(k);
      step;
      ack_i = 1'b0;
      chk($sformatf("full.rsp%0d", k), rsp_dat_o, 16'hA000 + 16'(k));
      rsp_ready_i = 1'b1;
      step;
      rsp_ready_i = 1'b0;
      if (k == 0) chk("full.push_at_pop", cmd_ready_o, 1);
    end
    chk("full.end_busy", busy_o, 0);
  endtask

  task automatic seq_reset;
    cmd_we_i  = 1'b1;
    cmd_sel_i = 2'b11;
    cmd_dat_i = 16'hCAFE;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_adr_i = 32'h200 + 32'(i);
      step;
    end
    cmd_valid_i = 1'b0;
    chk("rst.mid_cyc", cyc_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst.cyc", cyc_o, 0);
    chk("rst.stb", stb_o, 0);
    chk("rst.we", we_o, 0);
    chk("rst.adr", adr_o, 0);
    chk("rst.dat", dat_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.ready", cmd_ready_o, 1);
    chk("rst.rsp_valid", rsp_valid_o, 0);
    step;
    rst_i = 1'b0;
    ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("rst.after_cyc", cyc_o, 0);
      chk("rst.after_rsp", rsp_valid_o, 0);
    end
    ack_i = 1'b0;
    chk("rst.after_busy", busy_o, 0);
  endtask

  // Reference model: queue of accepted commands plus the one in flight.
  task automatic rand_run;
    cmd_t mq[$];
    cmd_t cur, nc;
    int          phase;
    int unsigned bw, bcnt, k;
    logic        e_err, exp_rdy;
    logic [15:0] e_dat;
    logic        do_push;
    phase = 0;
    bw = 0;
    bcnt = 0;
    e_err = 1'b0;
    e_dat = '0;
    cur = '{1'b0, 32'h0, 16'h0, 2'b00};
    for (int c = 0; c < 900; c++) begin
      if (c >= 450 && mq.size() == 0 && phase == 0) break;
      exp_rdy = (mq.size() < 4) || (phase == 0 && mq.size() > 0);
      chk("rnd.ready", cmd_ready_o, exp_rdy);
      chk("rnd.busy", busy_o, (mq.size() > 0) || (phase != 0));
      chk("rnd.cyc", cyc_o, phase == 1);
      chk("rnd.rsp_valid", rsp_valid_o, phase == 2);
      chk("rnd.adr", adr_o, (phase == 1) ? cur.adr : 32'h0);
      chk("rnd.we", we_o, (phase == 1) ? cur.we : 1'b0);
      chk("rnd.dat", dat_o, (phase == 1) ? cur.dat : 16'h0);
      chk("rnd.sel", sel_o, (phase == 1) ? cur.sel : 2'b00);
      if (phase == 2) begin
        chk("rnd.rsp_err", rsp_err_o, e_err);
        chk("rnd.rsp_dat", rsp_dat_o, e_dat);
      end
      nc.we  = 1'($urandom);
      nc.adr = $urandom;
      nc.dat = 16'($urandom);
      nc.sel = 2'($urandom);
      cmd_valid_i = (c < 450) && ($urandom_range(0, 9) < 6);
      cmd_we_i    = nc.we;
      cmd_adr_i   = nc.adr;
      cmd_dat_i   = nc.dat;
      cmd_sel_i   = nc.sel;
      rsp_ready_i = 1'($urandom_range(0, 1));
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = 16'($urandom);
      if (phase == 1 && bcnt == bw) begin
        k = $urandom_range(0, 9);
        ack_i = (k < 8);
        err_i = (k >= 6);
      end
      do_push = cmd_valid_i && exp_rdy;
      case (phase)
        0: if (mq.size() > 0) begin
             cur   = mq.pop_front();
             phase = 1;
             bcnt  = 0;
             bw    = $urandom_range(0, 3);
           end
        1: if (ack_i || err_i) begin
             phase = 2;
             e_err = err_i;
             e_dat = (ack_i && !err_i && !cur.we) ? dat_i : 16'h0;
           end else begin
             bcnt++;
           end
        default: if (rsp_ready_i) phase = 0;
      endcase
      if (do_push) mq.push_back(nc);
      step;
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    ack_i = 1'b0;
    err_i = 1'b0;
    chk("rnd.drained", (mq.size() == 0) && (phase == 0), 1);
    chk("rnd.end_busy", busy_o, 0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t tv;
    #1;
    chk("reset.cyc", cyc_o, 0);
    chk("reset.stb", stb_o, 0);
    chk("reset.adr", adr_o, 0);
    chk("reset.busy", busy_o, 0);
    chk("reset.ready", cmd_ready_o, 1);
    chk("reset.rsp_valid", rsp_valid_o, 0);
    chk("reset.rsp_err", rsp_err_o, 0);
    step;
    step;
    rst_i = 1'b0;
    step;

    tbl[0] = '{1'b1, 32'h10,        16'hBEEF, 2'b11, 2, 1'b1, 1'b0, 16'h5555, 3, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 32'h20,        16'h0000, 2'b11, 0, 1'b1, 1'b0, 16'h1234, 1, 1'b0, 16'h1234};
    tbl[2] = '{1'b0, 32'h24,        16'h0000, 2'b11, 0, 1'b1, 1'b1, 16'hA5A5, 1, 1'b1, 16'h0000};
    tbl[3] = '{1'b1, 32'h30,        16'h00FF, 2'b01, 1, 1'b0, 1'b1, 16'h3C3C, 2, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 32'hFFFF_FFFC, 16'h0000, 2'b10, 3, 1'b1, 1'b0, 16'hFFFF, 4, 1'b0, 16'hFFFF};
    tbl[5] = '{1'b0, 32'h40,        16'h0000, 2'b01, 0, 1'b0, 1'b1, 16'h7777, 1, 1'b1, 16'h0000};
    for (int i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

`ifdef WB_MASTER_TIMEOUT_EN
    tv = '{1'b0, 32'h50, 16'h0000, 2'b11, 0, 1'b0, 1'b0, 16'h0000, 8, 1'b1, 16'h0000};
    do_txn(tv, "timeout");
    tv = '{1'b0, 32'h54, 16'h0000, 2'b11, 7, 1'b1, 1'b0, 16'h7E57, 8, 1'b0, 16'h7E57};
    do_txn(tv, "timeout_ack_wins");
`else
    tv = '{1'b0, 32'h58, 16'h0000, 2'b11, 30, 1'b1, 1'b0, 16'h0BAD, 31, 1'b0, 16'h0BAD};
    do_txn(tv, "no_timeout");
`endif

    seq_full();
    seq_reset();
    rand_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
